// File: rtl/lsu_dmem.sv
// Load/store unit between the core datapath and data memory: classifies a request,
// issues one word-aligned memory access with byte enables, and returns formatted load data.
module lsu_dmem #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_vld,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_req_rdy,
    output logic        o_rsp_vld,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_stall,
    output logic        o_mem_vld,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_rdy,
    input  logic        i_mem_rvld,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        illegal, misaligned, bad;
    logic        timeout;

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = 4'b0011 << off;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   lane_wdata = {4{wd[7:0]}};
            2'b01:   lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = b;
            3'b001:  r = h;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        fmt_load = r;
    endfunction

    always_comb begin
        illegal    = i_req_we ? (i_req_funct3 > 3'b010)
                              : (i_req_funct3 == 3'b011 || i_req_funct3[2:1] == 2'b11);
        misaligned = (i_req_funct3[1:0] == 2'b01 && i_req_addr[0]) ||
                     (i_req_funct3 == 3'b010 && i_req_addr[1:0] != 2'b00);
        bad        = illegal || misaligned;
        timeout    = (cnt == TO_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == REQ && i_mem_rdy)
                cnt <= 16'd0;
            else if (state == WAIT && !i_mem_rvld && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_req_vld) state_nxt = bad ? RESP : REQ;
            REQ:  if (i_mem_rdy) state_nxt = we_q ? RESP : WAIT;
            WAIT: if (i_mem_rvld || timeout) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request/response holding registers; outputs are gated by state so no reset is needed here
    always_ff @(posedge i_clk) begin
        if (state == IDLE && i_req_vld) begin
            we_q    <= i_req_we;
            f3_q    <= i_req_funct3;
            addr_q  <= i_req_addr;
            be_q    <= lane_be(i_req_funct3[1:0], i_req_addr[1:0]);
            wdata_q <= lane_wdata(i_req_funct3[1:0], i_req_wdata);
            err_q   <= bad;
            rdata_q <= 32'd0;
        end else if (state == WAIT) begin
            if (i_mem_rvld) begin
                rdata_q <= fmt_load(f3_q, addr_q[1:0], i_mem_rdata);
                err_q   <= 1'b0;
            end else if (timeout) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        o_req_rdy   = (state == IDLE);
        o_stall     = (state != IDLE);
        o_mem_vld   = (state == REQ);
        o_mem_we    = o_mem_vld & we_q;
        o_mem_addr  = o_mem_vld ? {addr_q[31:2], 2'b00} : 32'd0;
        o_mem_be    = o_mem_vld ? be_q : 4'd0;
        o_mem_wdata = o_mem_vld ? wdata_q : 32'd0;
        o_rsp_vld   = (state == RESP);
        o_rsp_rdata = o_rsp_vld ? rdata_q : 32'd0;
        o_rsp_err   = o_rsp_vld & err_q;
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: directed scenarios plus randomized accesses checked against
// an arithmetic model of sizing, lane selection, extension and latency.
module tb_lsu_dmem;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld, req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr, req_wdata;
    logic        req_rdy, rsp_vld, rsp_err, stall;
    logic [31:0] rsp_rdata;
    logic        mem_vld, mem_we, mem_rdy, mem_rvld;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_dmem #(.TIMEOUT_CYC(TO)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req_vld(req_vld), .i_req_we(req_we), .i_req_funct3(req_f3),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_req_rdy(req_rdy), .o_rsp_vld(rsp_vld), .o_rsp_rdata(rsp_rdata),
        .o_rsp_err(rsp_err), .o_stall(stall),
        .o_mem_vld(mem_vld), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
        .i_mem_rdy(mem_rdy), .i_mem_rvld(mem_rvld), .i_mem_rdata(mem_rdata)
    );

    // ---------------- reference model ----------------
    function automatic bit m_bad(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int  size;
        bit  legal;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        return !legal || ((a % size) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int size;
        size = 1 << f3[1:0];
        return 4'(((1 << size) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'd0:    return (wd & 32'hFF) * 32'h0101_0101;
            2'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] w);
        int     nb;
        longint v;
        nb = 8 << f3[1:0];
        v  = longint'(w >> (8 * (a % 4))) & ((64'd1 << nb) - 1);
        if (!f3[2] && nb < 32 && v >= (64'd1 << (nb - 1)))
            v = v - (64'd1 << nb);
        return v[31:0];
    endfunction

    function automatic bit m_timeout(input bit we, input int rvld_wait);
        return !we && (rvld_wait < 0 || rvld_wait >= TO);
    endfunction

    function automatic int m_lat(input bit we, input bit bad, input int rdy_wait,
                                 input int rvld_wait);
        if (bad) return 1;
        if (we) return 2 + rdy_wait;
        if (m_timeout(we, rvld_wait)) return 2 + rdy_wait + TO;
        return 3 + rdy_wait + rvld_wait;
    endfunction

    // ---------------- stimulus driver (memory responder included) ----------------
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rword,
                              input int rdy_wait, input int rvld_wait,
                              output logic got_vld, output logic got_err,
                              output logic [31:0] got_rdata, output int lat,
                              output logic mv_seen, output logic [31:0] maddr,
                              output logic [31:0] mwdata, output logic [3:0] mbe,
                              output logic mwe, output logic stable, output logic stall_ok);
        int guard = 0;
        int mv = 0;
        int wstart = 0;
        while (!req_rdy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_vld = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wdata;
        got_vld = 0; got_err = 0; got_rdata = 0; lat = 0; mv_seen = 0;
        maddr = 0; mwdata = 0; mbe = 0; mwe = 0; stable = 1; stall_ok = 1;
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            req_vld = 1'b0;
            if (!stall || req_rdy) stall_ok = 0;
            if (rsp_vld) begin
                got_vld = 1; got_err = rsp_err; got_rdata = rsp_rdata; lat = c;
                break;
            end
            if (mem_vld) begin
                if (!mv_seen) begin
                    maddr = mem_addr; mwdata = mem_wdata; mbe = mem_be; mwe = mem_we;
                end else if (maddr !== mem_addr || mwdata !== mem_wdata ||
                             mbe !== mem_be || mwe !== mem_we) begin
                    stable = 0;
                end
                mv_seen = 1;
                mv++;
                mem_rdy = (mv > rdy_wait);
                if (mem_rdy && !we) wstart = c + 1;
            end else begin
                mem_rdy = 1'b0;
            end
            mem_rvld  = (wstart > 0 && rvld_wait >= 0 && c == wstart + rvld_wait);
            mem_rdata = mem_rvld ? rword : $urandom();
        end
        mem_rdy = 1'b0;
        mem_rvld = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    logic        g_vld, g_err, g_mv, g_we, g_stable, g_stall;
    logic [31:0] g_rdata, g_maddr, g_mwdata;
    logic [3:0]  g_be;
    int          g_lat;
    logic [105:0] idle_vec;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle_vec = {req_rdy, rsp_vld, rsp_err, stall, mem_vld, mem_we, mem_be,
                    mem_addr, mem_wdata, rsp_rdata};
        checks++;
        if (idle_vec !== {1'b1, 105'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", idle_vec, {1'b1, 105'd0});
        end
    endtask

    task automatic test_store_word();
        run_access(1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, -1, g_vld, g_err, g_rdata,
                   g_lat, g_mv, g_maddr, g_mwdata, g_be, g_we, g_stable, g_stall);
        checks++;
        if ({g_vld, g_err, g_rdata} !== {1'b1, 1'b0, 32'd0} || g_lat !== 2) begin
            errors++;
            $display("FAIL sw_rsp: vld=%b err=%b rdata=%h lat=%0d expected 1 0 0 2",
                     g_vld, g_err, g_rdata, g_lat);
        end
        checks++;
        if ({g_maddr, g_be, g_we, g_mwdata} !== {32'h104, 4'hF, 1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL sw_mem: addr=%h be=%b we=%b wdata=%h expected 104 1111 1 deadbeef",
                     g_maddr, g_be, g_we, g_mwdata);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] ads [3] = '{32'h103, 32'h103, 32'h102};
        logic [31:0] exps[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80AA};
        for (int i = 0; i < 3; i++) begin
            run_access(0, f3s[i], ads[i], 32'h0, 32'h80AA_BBCC, 0, 0, g_vld, g_err, g_rdata,
                       g_lat, g_mv, g_maddr, g_mwdata, g_be, g_we, g_stable, g_stall);
            checks++;
            if ({g_vld, g_err, g_rdata} !== {1'b1, 1'b0, exps[i]} || g_lat !== 3) begin
                errors++;
                $display("FAIL load_ext[%0d]: vld=%b err=%b rdata=%h lat=%0d expected rdata %h lat 3",
                         i, g_vld, g_err, g_rdata, g_lat, exps[i]);
            end
        end
    endtask

    task automatic test_store_half();
        run_access(1, 3'b001, 32'h202, 32'h0000_1234, 0, 0, -1, g_vld, g_err, g_rdata,
                   g_lat, g_mv, g_maddr, g_mwdata, g_be, g_we, g_stable, g_stall);
        checks++;
        if ({g_maddr, g_be, g_mwdata} !== {32'h200, 4'b1100, 32'h1234_1234} || g_err !== 1'b0) begin
            errors++;
            $display("FAIL sh_mem: addr=%h be=%b wdata=%h err=%b expected 200 1100 12341234 0",
                     g_maddr, g_be, g_mwdata, g_err);
        end
    endtask

    task automatic test_errors();
        logic        wes [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [4] = '{3'b101, 3'b010, 3'b100, 3'b110};
        logic [31:0] ads [4] = '{32'h101, 32'h106, 32'h100, 32'h100};
        for (int i = 0; i < 4; i++) begin
            run_access(wes[i], f3s[i], ads[i], 32'h5555_AAAA, 32'h1357_9BDF, 0, 0, g_vld,
                       g_err, g_rdata, g_lat, g_mv, g_maddr, g_mwdata, g_be, g_we,
                       g_stable, g_stall);
            checks++;
            if ({g_vld, g_err, g_rdata, g_mv} !== {1'b1, 1'b1, 32'd0, 1'b0} || g_lat !== 1) begin
                errors++;
                $display("FAIL err_case[%0d]: vld=%b err=%b rdata=%h memvld=%b lat=%0d expected 1 1 0 0 1",
                         i, g_vld, g_err, g_rdata, g_mv, g_lat);
            end
        end
    endtask

    task automatic test_stall_timeout();
        run_access(0, 3'b010, 32'h300, 32'h0, 32'hAAAA_5555, 3, -1, g_vld, g_err, g_rdata,
                   g_lat, g_mv, g_maddr, g_mwdata, g_be, g_we, g_stable, g_stall);
        checks++;
        if ({g_mv, g_stable, g_stall, g_maddr, g_be, g_we} !== {3'b111, 32'h300, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold: memvld=%b stable=%b stall=%b addr=%h be=%b we=%b expected 1 1 1 300 1111 0",
                     g_mv, g_stable, g_stall, g_maddr, g_be, g_we);
        end
        checks++;
        if ({g_vld, g_err, g_rdata} !== {1'b1, 1'b1, 32'd0} || g_lat !== 2 + 3 + TO) begin
            errors++;
            $display("FAIL timeout: vld=%b err=%b rdata=%h lat=%0d expected 1 1 0 %0d",
                     g_vld, g_err, g_rdata, g_lat, 2 + 3 + TO);
        end
        run_access(0, 3'b010, 32'h304, 32'h0, 32'h0F0F_1234, 0, TO - 1, g_vld, g_err, g_rdata,
                   g_lat, g_mv, g_maddr, g_mwdata, g_be, g_we, g_stable, g_stall);
        checks++;
        if ({g_vld, g_err, g_rdata} !== {1'b1, 1'b0, 32'h0F0F_1234} || g_lat !== 2 + TO) begin
            errors++;
            $display("FAIL rvld_on_last_count: vld=%b err=%b rdata=%h lat=%0d expected 1 0 0f0f1234 %0d",
                     g_vld, g_err, g_rdata, g_lat, 2 + TO);
        end
    endtask

    task automatic test_reset_mid();
        int  guard = 0;
        logic saw_rsp = 1'b0;
        while (!req_rdy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_vld = 1'b1; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h40;
        @(negedge clk);
        req_vld = 1'b0;
        mem_rdy = 1'b1;
        @(negedge clk);
        mem_rdy = 1'b0;
        checks++;
        if ({stall, mem_vld, rsp_vld} !== 3'b100) begin
            errors++;
            $display("FAIL wait_state: stall/memvld/rspvld=%b expected 100", {stall, mem_vld, rsp_vld});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_vec = {req_rdy, rsp_vld, rsp_err, stall, mem_vld, mem_we, mem_be,
                    mem_addr, mem_wdata, rsp_rdata};
        checks++;
        if (idle_vec !== {1'b1, 105'd0}) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected %h", idle_vec, {1'b1, 105'd0});
        end
        mem_rvld = 1'b1;
        mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rvld = 1'b0;
            if (rsp_vld || !req_rdy) saw_rsp = 1'b1;
        end
        checks++;
        if (saw_rsp !== 1'b0) begin
            errors++;
            $display("FAIL late_rvld_ignored: rsp seen=%b expected 0", saw_rsp);
        end
        run_access(0, 3'b010, 32'h80, 32'h0, 32'hCAFE_BABE, 0, 0, g_vld, g_err, g_rdata,
                   g_lat, g_mv, g_maddr, g_mwdata, g_be, g_we, g_stable, g_stall);
        checks++;
        if ({g_vld, g_err, g_rdata} !== {1'b1, 1'b0, 32'hCAFE_BABE} || g_lat !== 3) begin
            errors++;
            $display("FAIL post_reset_lw: vld=%b err=%b rdata=%h lat=%0d expected 1 0 cafebabe 3",
                     g_vld, g_err, g_rdata, g_lat);
        end
    endtask

    task automatic test_back_to_back();
        run_access(1, 3'b000, 32'h11, 32'h77, 32'h0, 0, -1, g_vld, g_err, g_rdata,
                   g_lat, g_mv, g_maddr, g_mwdata, g_be, g_we, g_stable, g_stall);
        @(negedge clk);
        checks++;
        if ({req_rdy, rsp_vld, stall} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_idle: rdy/rspvld/stall=%b expected 100", {req_rdy, rsp_vld, stall});
        end
        run_access(0, 3'b100, 32'h11, 32'h0, 32'h0000_F500, 0, 0, g_vld, g_err, g_rdata,
                   g_lat, g_mv, g_maddr, g_mwdata, g_be, g_we, g_stable, g_stall);
        checks++;
        if ({g_vld, g_err, g_rdata, g_be} !== {1'b1, 1'b0, 32'h0000_00F5, 4'b0010}) begin
            errors++;
            $display("FAIL b2b_lbu: vld=%b err=%b rdata=%h be=%b expected 1 0 000000f5 0010",
                     g_vld, g_err, g_rdata, g_be);
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd, rw;
        int          rdw, rvw;
        bit          bad;
        for (int i = 0; i < 40; i++) begin
            we  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom();
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd  = $urandom();
            rw  = $urandom();
            rdw = $urandom_range(0, 2);
            rvw = $urandom_range(0, TO);
            bad = m_bad(we, f3, a);
            run_access(we, f3, a, wd, rw, rdw, rvw, g_vld, g_err, g_rdata, g_lat, g_mv,
                       g_maddr, g_mwdata, g_be, g_we, g_stable, g_stall);
            checks++;
            if (g_vld !== 1'b1 || g_lat !== m_lat(we, bad, rdw, rvw) ||
                g_err !== (bad || m_timeout(we, rvw)) ||
                g_rdata !== ((bad || we || m_timeout(we, rvw)) ? 32'd0 : m_rdata(f3, a, rw)) ||
                g_mv !== !bad) begin
                errors++;
                $display("FAIL rand_rsp[%0d]: we=%b f3=%b a=%h vld=%b err=%b rdata=%h lat=%0d memvld=%b expected lat=%0d bad=%b",
                         i, we, f3, a, g_vld, g_err, g_rdata, g_lat, g_mv,
                         m_lat(we, bad, rdw, rvw), bad);
            end
            if (!bad) begin
                checks++;
                if (g_maddr !== {a[31:2], 2'b00} || g_be !== m_be(f3, a) || g_we !== we ||
                    g_mwdata !== (we ? m_wdata(f3, wd) : m_wdata(f3, 32'h0) | (we ? 32'h0 : g_mwdata & 32'h0) | (we ? 32'h0 : m_wdata(f3, wd))) ||
                    !g_stable || !g_stall) begin
                    errors++;
                    $display("FAIL rand_mem[%0d]: addr=%h be=%b we=%b wdata=%h stable=%b stall=%b expected be=%b",
                             i, g_maddr, g_be, g_we, g_mwdata, g_stable, g_stall, m_be(f3, a));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; req_vld = 1'b0; req_we = 1'b0; req_f3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_rdy = 1'b0; mem_rvld = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_store_word();
        test_load_ext();
        test_store_half();
        test_errors();
        test_stall_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
Load/store unit that executes the data-memory requests raised by the decode stage. It sits between the core datapath and data memory.
- Core side: accepts a load or store with funct3, address and store data.
- Memory side: issues a word-aligned access with byte enables over a valid/ready handshake, then waits for read data.
- Returns sign- or zero-extended load data, or an error for misaligned, illegal or timed-out accesses.

Parameters:
TIMEOUT_CYC, 255, maximum cycles spent in WAIT for i_mem_rvld before the access is aborted with error; legal range 1..65535.

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_req_vld  in  1  core request valid
i_req_we  in  1  1 = store, 0 = load
i_req_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_req_addr  in  32  byte address
i_req_wdata  in  32  store data, right-aligned
o_req_rdy  out  1  unit can accept a request; high only in IDLE
o_rsp_vld  out  1  one-cycle completion pulse
o_rsp_rdata  out  32  formatted load data; 0 for stores and errors
o_rsp_err  out  1  qualified by o_rsp_vld: misaligned, illegal funct3 or timeout
o_stall  out  1  high in REQ, WAIT and RESP
o_mem_vld  out  1  memory request valid
o_mem_we  out  1  memory write enable
o_mem_addr  out  32  {addr[31:2], 2'b00}
o_mem_be  out  4  byte enables
o_mem_wdata  out  32  lane-replicated store data
i_mem_rdy  in  1  memory accepts the request
i_mem_rvld  in  1  read data valid
i_mem_rdata  in  32  read word

Behaviour:
- Clocking and reset: one clock, i_clk. i_reset is synchronous and active-high.
- Reset state: IDLE; all registered outputs 0 (o_mem_*, o_rsp_*); timeout counter 0. o_req_rdy reads 1 after reset.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: o_req_rdy = 1. On i_req_vld, latch the request, then classify it:
  - Illegal: store with funct3 > 010, or load with funct3 in {011, 110, 111}.
  - Misaligned: H/HU with addr[0] = 1, or W with addr[1:0] != 0.
  - Illegal or misaligned: go to RESP with err = 1. No memory access occurs.
  - Otherwise: go to REQ.
- Byte enables and store data (off = addr[1:0]):
  - B/BU: be = 0001 << off; wdata = {4{wdata[7:0]}}.
  - H/HU: be = 0011 << off; wdata = {2{wdata[15:0]}}.
  - W: be = 1111; wdata = wdata.
  - Loads drive the same be pattern with o_mem_we = 0.
- REQ:
  - o_mem_vld = 1, and all o_mem_* fields stay stable until i_mem_rdy is seen high.
  - On the handshake cycle: store goes to RESP; load goes to WAIT with the counter cleared.
- WAIT:
  - i_mem_rvld is honoured only in this state; it is ignored in all other states.
  - On i_mem_rvld, capture and format the data, then go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYC - 1 with no rvld, go to RESP with err = 1 and rdata = 0.
  - rvld in the same cycle as the final count wins (no error).
- Load data formatting, selecting lane off:
  - LB: sign-extend byte [8*off+7 : 8*off].
  - LBU: zero-extend the same byte.
  - LH: sign-extend half [16*off[1]+15 : 16*off[1]].
  - LHU: zero-extend the same half.
  - LW: full word.
- RESP: o_rsp_vld = 1 for exactly one cycle, then return to IDLE. A new request can be accepted in the following cycle.
- Latency, accept cycle T with zero-wait memory:
  - Store: REQ at T+1, rsp_vld at T+2.
  - Load with rvld in the first WAIT cycle: rsp_vld at T+3.
  - Error: rsp_vld at T+1.
- o_rsp_rdata and o_rsp_err hold their values only while o_rsp_vld is high; they are 0 otherwise.
- Reset mid-operation (any state):
  - Next edge returns the unit to IDLE and drops o_mem_vld; no o_rsp_vld is issued.
  - A late i_mem_rvld arriving after reset is ignored.
- The counter is wide enough for TIMEOUT_CYC (16 bits) and saturates; it never wraps.

Test Plan:
- SW addr 0x0000_0104, wdata 0xDEADBEEF, i_mem_rdy tied 1 -> o_mem_addr 0x104, be 1111, we 1; rsp_vld 2 cycles after accept, err 0, rdata 0.
- LB addr 0x103, i_mem_rdata 0x80AA_BBCC -> rdata 0xFFFF_FF80; LBU at the same addr -> 0x0000_0080; LH addr 0x102 -> 0xFFFF_80AA.
- SH addr 0x202, wdata 0x0000_1234 -> be 1100, o_mem_wdata 0x1234_1234, o_mem_addr 0x200.
- LHU addr 0x101 and LW addr 0x106 -> o_mem_vld never asserted; rsp_vld one cycle after accept with err 1.
- Load with i_mem_rdy held low 3 cycles -> o_mem_vld stays high and o_mem_* stay stable; o_stall high; o_req_rdy low. Then no rvld for TIMEOUT_CYC = 4 cycles -> err 1, rdata 0.
- i_reset pulsed while in WAIT, then i_mem_rvld arrives -> IDLE on next edge; all outputs 0; no rsp_vld; a fresh LW then completes normally.
